axis_collector: RTL and testbench

- Reverse-direction counterpart of the PS-to-channel selector: merges up to 16 per-channel AXI-Stream sources (capture/readback data) into one 256-bit stream toward the pl_to_ps path.
- Packet-atomic round-robin arbitration; a packet owns the output from grant until its tlast beat.
- Output is registered through a 2-entry skid slice; the source channel index is carried on m_axis_tuser.

---
 rtl/rfsoc_axis_pkg.sv | 7 +
 rtl/axis_skid_slice.sv | 41 ++++
 rtl/axis_collector.sv | 81 ++++++++
 tb/tb_axis_collector.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rfsoc_axis_pkg.sv
// rfsoc_axis_pkg: shared AXI-Stream channel definitions for the PS<->channel fabric.
package rfsoc_axis_pkg;
  localparam int NUM_CH_DEFAULT = 16;
  localparam int AXIS_DATA_W = 256;
  typedef logic [3:0] ch_idx_t;
  typedef enum logic {IDLE, LOCKED} coll_state_t;
endpackage

// File: rtl/axis_skid_slice.sv
// axis_skid_slice: 2-entry AXI-Stream register slice with a registered upstream ready.
module axis_skid_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic rdy_q, push, pop;
  assign push = in_valid & rdy_q;
  assign pop = out_valid & out_ready;
  assign out_valid = cnt_q != 2'd0;
  assign out_data = e0_q;
  assign in_ready = rdy_q;
  // e0 is always the head; e1 only fills when the head is occupied and not leaving
  always_comb begin
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    e0_d = (pop && cnt_q == 2'd2) ? e1_q : (push && (cnt_q == 2'd0 || pop)) ? in_data : e0_q;
    e1_d = (push && !pop && cnt_q == 2'd1) ? in_data : e1_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= 2'd0;
      rdy_q <= 1'b1;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
      rdy_q <= cnt_d != 2'd2;
    end
  end
endmodule

// File: rtl/axis_collector.sv
// axis_collector: packet-atomic round-robin merge of per-channel AXI-Streams into one stream,
// tagging each beat with its source channel on tuser.
module axis_collector
  import rfsoc_axis_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int DATA_W = AXIS_DATA_W,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        channel_enable,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic [CH_W-1:0]          m_axis_tuser,
  input  logic                     m_axis_tready,
  output logic [31:0]              pkt_count,
  output logic                     busy
);
  coll_state_t state_q, state_d;
  logic [CH_W-1:0] rr_q, rr_d, grant_q, grant_d, pick, idx;
  logic [NUM_CH-1:0] req;
  logic slice_rdy, in_valid, accept;
  logic [31:0] pkt_q;
  assign req = s_axis_tvalid & channel_enable;
  assign in_valid = state_q == LOCKED && s_axis_tvalid[grant_q];
  assign accept = in_valid && slice_rdy;
  assign s_axis_tready = (state_q == LOCKED && slice_rdy) ? NUM_CH'(1) << grant_q : '0;
  assign busy = state_q == LOCKED || m_axis_tvalid;
  assign pkt_count = pkt_q;
  // scan downward so the candidate closest to rr_q is the last to be written
  always_comb begin
    pick = '0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(rr_q) + i) % NUM_CH);
      pick = req[idx] ? idx : pick;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    if (state_q == IDLE && |req) begin
      state_d = LOCKED;
      grant_d = pick;
    end
    if (accept && s_axis_tlast[grant_q]) begin
      state_d = IDLE;
      rr_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      rr_q <= '0;
      grant_q <= '0;
      pkt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      pkt_q <= pkt_q + {31'd0, m_axis_tvalid & m_axis_tready & m_axis_tlast};
    end
  end
  axis_skid_slice #(.W(DATA_W + 1 + CH_W)) u_slice (
    .clk(clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in_data({s_axis_tlast[grant_q], grant_q, s_axis_tdata[grant_q*DATA_W +: DATA_W]}),
    .in_ready(slice_rdy),
    .out_valid(m_axis_tvalid),
    .out_data({m_axis_tlast, m_axis_tuser, m_axis_tdata}),
    .out_ready(m_axis_tready)
  );
endmodule

// File: tb/tb_axis_collector.sv
// tb_axis_collector: directed scenario bench for axis_collector.
module tb_axis_collector;
  localparam int NUM_CH = 16;
  localparam int DATA_W = 256;
  logic clk = 1'b0;
  logic rstn;
  logic [NUM_CH-1:0] channel_enable;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
  logic [NUM_CH-1:0] s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready, busy;
  logic [3:0] m_axis_tuser;
  logic [31:0] pkt_count;
  int n_cmp = 0, n_bad = 0;
  int rem[NUM_CH], bidx[NUM_CH], plen[NUM_CH], npk[NUM_CH];
  logic [DATA_W-1:0] obs_d[64];
  logic [3:0] obs_u[64];
  logic obs_l[64];
  int n_obs, nin, cyc, n_acc7;
  int acc_cyc[16];
  logic s_v, s_r;
  logic [DATA_W-1:0] s_d;

  always #5 clk = ~clk;

  axis_collector dut (
    .clk(clk), .rstn(rstn), .channel_enable(channel_enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .pkt_count(pkt_count), .busy(busy)
  );

  function automatic logic [DATA_W-1:0] beat(int c, int i);
    logic [31:0] w;
    w = 32'((c << 16) | i);
    return {8{w}};
  endfunction

  task automatic drive();
    for (int c = 0; c < NUM_CH; c++) begin
      s_axis_tvalid[c] = rem[c] != 0;
      s_axis_tlast[c] = rem[c] == 1;
      s_axis_tdata[c*DATA_W +: DATA_W] = beat(c, bidx[c]);
    end
  endtask

  task automatic step();
    logic [NUM_CH-1:0] hs;
    logic ohs, ol;
    logic [3:0] ou;
    logic [DATA_W-1:0] od;
    @(negedge clk);
    hs = s_axis_tvalid & s_axis_tready;
    ohs = m_axis_tvalid & m_axis_tready;
    od = m_axis_tdata;
    ou = m_axis_tuser;
    ol = m_axis_tlast;
    s_v = m_axis_tvalid;
    s_r = m_axis_tready;
    s_d = m_axis_tdata;
    @(posedge clk);
    #1;
    cyc++;
    if (ohs && n_obs < 64) begin
      obs_d[n_obs] = od;
      obs_u[n_obs] = ou;
      obs_l[n_obs] = ol;
      n_obs++;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (hs[c]) begin
        nin++;
        if (c == 7 && n_acc7 < 16) begin
          acc_cyc[n_acc7] = cyc;
          n_acc7++;
        end
        bidx[c]++;
        rem[c]--;
        if (rem[c] == 0 && npk[c] > 0) begin
          rem[c] = plen[c];
          npk[c]--;
          bidx[c] = 0;
        end
      end
    end
    drive();
  endtask

  task automatic test_reset();
    channel_enable = '1;
    m_axis_tready = 1'b1;
    s_axis_tvalid = '1;
    s_axis_tlast = '0;
    s_axis_tdata = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (s_axis_tready !== '0) begin n_bad++; $display("FAIL reset_tready got %h want 0", s_axis_tready); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_mvalid got %b want 0", m_axis_tvalid); end
    n_cmp++; if (pkt_count !== 32'd0) begin n_bad++; $display("FAIL reset_pktcnt got %0d want 0", pkt_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    for (int c = 0; c < NUM_CH; c++) begin rem[c] = 0; bidx[c] = 0; plen[c] = 0; npk[c] = 0; end
    drive();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_round_robin();
    int exp_ch[6];
    exp_ch = '{0, 0, 5, 5, 15, 15};
    n_obs = 0;
    rem[0] = 2; rem[5] = 2; rem[15] = 2;
    drive();
    for (int k = 0; k < 60 && n_obs < 6; k++) step();
    n_cmp++; if (n_obs !== 6) begin n_bad++; $display("FAIL rr_beats got %0d want 6", n_obs); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (obs_u[k] !== 4'(exp_ch[k]) || obs_l[k] !== (k % 2 == 1) || obs_d[k] !== beat(exp_ch[k], k % 2)) begin
        n_bad++;
        $display("FAIL rr_beat%0d got ch %0d last %b want ch %0d last %b", k, obs_u[k], obs_l[k], exp_ch[k], k % 2 == 1);
      end
    end
    n_cmp++; if (pkt_count !== 32'd3) begin n_bad++; $display("FAIL rr_pktcnt got %0d want 3", pkt_count); end
  endtask

  task automatic test_masking();
    int bad1;
    bad1 = 0;
    n_obs = 0;
    channel_enable = 16'h0004;
    rem[1] = 4; rem[2] = 4; bidx[1] = 0; bidx[2] = 0;
    drive();
    for (int k = 0; k < 60 && n_obs < 4; k++) begin
      step();
      if (s_axis_tready[1]) bad1++;
      if (rem[2] < 4) channel_enable = 16'h0000;
    end
    n_cmp++; if (n_obs !== 4) begin n_bad++; $display("FAIL mask_beats got %0d want 4", n_obs); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (obs_u[k] !== 4'd2 || obs_l[k] !== (k == 3) || obs_d[k] !== beat(2, k)) begin
        n_bad++;
        $display("FAIL mask_beat%0d got ch %0d last %b want ch 2 last %b", k, obs_u[k], obs_l[k], k == 3);
      end
    end
    n_cmp++; if (bad1 !== 0 || rem[1] !== 4) begin n_bad++; $display("FAIL mask_ch1 got %0d ready cycles rem %0d want 0 rem 4", bad1, rem[1]); end
    n_cmp++; if (pkt_count !== 32'd4) begin n_bad++; $display("FAIL mask_pktcnt got %0d want 4", pkt_count); end
    rem[1] = 0;
    drive();
    step();
    channel_enable = '1;
  endtask

  task automatic test_backpressure();
    int nin0, occ, max_occ, stall_bad;
    logic pv, pr;
    logic [DATA_W-1:0] pd;
    logic [3:0] pat;
    pat = 4'b1001;
    nin0 = nin; max_occ = 0; stall_bad = 0;
    n_obs = 0;
    rem[3] = 8; bidx[3] = 0;
    drive();
    pv = 1'b0; pr = 1'b1; pd = '0;
    for (int k = 0; k < 200 && n_obs < 8; k++) begin
      m_axis_tready = pat[k % 4];
      step();
      if (pv && !pr && (s_v !== 1'b1 || s_d !== pd)) stall_bad++;
      pv = s_v; pr = s_r; pd = s_d;
      occ = (nin - nin0) - n_obs;
      if (occ > max_occ) max_occ = occ;
    end
    m_axis_tready = 1'b1;
    n_cmp++; if (n_obs !== 8) begin n_bad++; $display("FAIL bp_beats got %0d want 8", n_obs); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (obs_d[k] !== beat(3, k) || obs_u[k] !== 4'd3 || obs_l[k] !== (k == 7)) begin
        n_bad++;
        $display("FAIL bp_beat%0d got %h ch %0d want idx %0d ch 3", k, obs_d[k][31:0], obs_u[k], k);
      end
    end
    n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL bp_stable got %0d unstable cycles want 0", stall_bad); end
    n_cmp++; if (max_occ > 2) begin n_bad++; $display("FAIL bp_occupancy got %0d want <=2", max_occ); end
    n_cmp++; if (pkt_count !== 32'd5) begin n_bad++; $display("FAIL bp_pktcnt got %0d want 5", pkt_count); end
  endtask

  task automatic test_single_beat();
    n_obs = 0; n_acc7 = 0;
    rem[7] = 1; bidx[7] = 0; plen[7] = 1; npk[7] = 4;
    drive();
    for (int k = 0; k < 60 && n_obs < 5; k++) step();
    n_cmp++; if (n_obs !== 5 || n_acc7 !== 5) begin n_bad++; $display("FAIL sb_count got %0d out %0d in want 5", n_obs, n_acc7); end
    for (int k = 1; k < 5; k++) begin
      n_cmp++;
      if (acc_cyc[k] - acc_cyc[k-1] !== 2) begin
        n_bad++;
        $display("FAIL sb_spacing%0d got %0d want 2", k, acc_cyc[k] - acc_cyc[k-1]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (obs_u[k] !== 4'd7 || obs_l[k] !== 1'b1 || obs_d[k] !== beat(7, 0)) begin
        n_bad++;
        $display("FAIL sb_beat%0d got ch %0d last %b want ch 7 last 1", k, obs_u[k], obs_l[k]);
      end
    end
    n_cmp++; if (pkt_count !== 32'd10) begin n_bad++; $display("FAIL sb_pktcnt got %0d want 10", pkt_count); end
  endtask

  task automatic test_reset_mid_packet();
    rem[9] = 6; bidx[9] = 0;
    drive();
    for (int k = 0; k < 40 && rem[9] > 3; k++) step();
    n_cmp++; if (rem[9] !== 3) begin n_bad++; $display("FAIL mr_progress got rem %0d want 3", rem[9]); end
    rem[9] = 0;
    drive();
    rstn = 1'b0;
    step();
    n_cmp++;
    if (s_axis_tready !== '0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 ||
        m_axis_tuser !== 4'd0 || pkt_count !== 32'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mr_outputs got rdy %h v %b l %b u %0d cnt %0d busy %b want all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, pkt_count, busy);
    end
    rstn = 1'b1;
    n_obs = 0;
    rem[0] = 2; bidx[0] = 0; rem[9] = 6; bidx[9] = 0;
    drive();
    for (int k = 0; k < 80 && n_obs < 8; k++) step();
    n_cmp++; if (n_obs !== 8) begin n_bad++; $display("FAIL mr_beats got %0d want 8", n_obs); end
    n_cmp++; if (obs_u[0] !== 4'd0 || obs_d[0] !== beat(0, 0)) begin n_bad++; $display("FAIL mr_first got ch %0d want 0", obs_u[0]); end
    n_cmp++; if (obs_u[2] !== 4'd9 || obs_d[2] !== beat(9, 0)) begin n_bad++; $display("FAIL mr_second got ch %0d want 9", obs_u[2]); end
    n_cmp++; if (pkt_count !== 32'd2) begin n_bad++; $display("FAIL mr_pktcnt got %0d want 2", pkt_count); end
  endtask

  initial begin
    n_obs = 0; nin = 0; cyc = 0; n_acc7 = 0;
    test_reset();
    test_round_robin();
    test_masking();
    test_backpressure();
    test_single_beat();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
